ram_burst_controller: RTL and testbench
=======================================

Name: ram_burst_controller

Overview:
Parametrised burst-mode front end for one MCB user port. It replaces single-word, one-command-per-access RAM handling with request/ready handshakes, multi-word write and read bursts, full-width port support and sticky error reporting. It sits between the project FSM and the MIG user port (p0), and both run on clk.

Parameters:
PORT_BITS, 32, MCB port data width. Legal values are 32, 64 and 128. Mask width is PORT_BITS/8.
MAX_BURST, 64, maximum words per burst. Legal range is 1..64.
ADDR_WIDTH, 26, word-address width on the user side.

Ports:
clk  in  1  single clock for the user side and all MCB p0 port clocks
reset  in  1  synchronous, active-low reset
req_valid  in  1  user request strobe
req_ready  out  1  controller can accept a request
req_write  in  1  1 = write burst, 0 = read burst
req_addr  in  ADDR_WIDTH  starting word address
req_len  in  7  burst length in words, 1..MAX_BURST
wr_valid  in  1  user write word valid
wr_ready  out  1  controller accepts a write word
wr_data  in  PORT_BITS  write word
rd_valid  out  1  read word valid
rd_ready  in  1  user accepts a read word
rd_data  out  PORT_BITS  read word
busy  out  1  burst in progress
error  out  1  sticky: illegal length, write underrun or read overflow
calib_done  in  1  MCB calibration complete
cmd_en  out  1  MCB command strobe
cmd_instr  out  3  3'b000 = write, 3'b001 = read
cmd_bl  out  6  burst length minus 1
cmd_byte_addr  out  30  byte address, req_addr * (PORT_BITS/8), zero-extended
cmd_full  in  1  MCB command FIFO full
mwr_en  out  1  MCB write FIFO push
mwr_data  out  PORT_BITS  MCB write data
mwr_mask  out  PORT_BITS/8  always 0 (full-word writes)
mwr_full  in  1  MCB write FIFO full
mwr_underrun  in  1  MCB write underrun flag
mrd_en  out  1  MCB read FIFO pop
mrd_data  in  PORT_BITS  MCB read data
mrd_empty  in  1  MCB read FIFO empty
mrd_overflow  in  1  MCB read overflow flag

Behaviour:
- Reset: takes effect on the clk edge while reset=0. State goes to FLUSH. All strobes are 0; req_ready=0, busy=0, error=0; counters and latched request are cleared.
- FLUSH: mrd_en = !mrd_empty, discarding stale read data left by an aborted burst. Move to WAIT_CAL when mrd_empty=1.
- WAIT_CAL: stay until calib_done=1, then move to IDLE.
- IDLE: req_ready=1 (registered), busy=0.
  - On req_valid && req_ready, latch addr, len and write.
  - If len=0 or len>MAX_BURST: set error, drop the request, stay in IDLE.
  - Otherwise: busy=1, count=0; go to WR_FILL if write, else RD_CMD.
- WR_FILL: wr_ready = !mwr_full. Each wr_valid && wr_ready drives mwr_en=1 and mwr_data=wr_data in the same cycle (combinational pass-through) and increments count. When count reaches len, go to WR_CMD. All data is loaded before the command is issued.
- WR_CMD: cmd_en=1 for exactly one cycle, in the first cycle where cmd_full=0. cmd_instr=000, cmd_bl=len-1. Then go to IDLE.
- RD_CMD: same as WR_CMD but cmd_instr=001. Then go to RD_DATA with count=0.
- RD_DATA: rd_valid = !mrd_empty; rd_data = mrd_data; mrd_en = rd_valid && rd_ready. Each pop increments count. When count reaches len, go to IDLE.
- Latency: a command reaches the MCB no earlier than 1 cycle after the last write word, or 1 cycle after request acceptance for reads.
- req_ready is 0 in every state except IDLE, so back-to-back requests have one idle cycle between them.
- error: sticky. It is set by an illegal length, by mwr_underrun=1 or by mrd_overflow=1 in any state, and is cleared only by reset. The state machine does not abort on error.
- Simultaneous events:
  - cmd_full held high: stay in the CMD state indefinitely, cmd_en=0.
  - wr_valid while mwr_full=1: no push, data held by the user.
  - rd_ready=0: the word stays in the MCB FIFO.
- The address does not wrap. cmd_byte_addr is the zero-extended product of req_addr and PORT_BITS/8. The caller guarantees the burst fits in memory.
- Reset mid-burst: the burst is abandoned; FLUSH discards any partial read data.

Test Plan:
1. Reset, then hold mrd_empty=0 for 3 cycles -> 3 mrd_en pulses; calib_done=1 -> IDLE with req_ready=1, error=0.
2. Write with req_addr=0x10, len=4, PORT_BITS=32 -> 4 mwr_en pulses with matching data, then one cmd_en with instr=000, bl=3, byte_addr=0x40; return to IDLE, busy=0.
3. Read with len=8, mrd_empty toggling, rd_ready=1 -> 8 rd_valid/mrd_en transfers in order, cmd bl=7 instr=001, then IDLE.
4. cmd_full=1 for 5 cycles during WR_CMD -> cmd_en stays 0, then exactly one cmd_en pulse after release.
5. req_len=0, then req_len=65 -> error=1, no cmd_en; a following legal request still completes with error still 1.
6. Assert reset after 2 of 8 read words, with mrd_empty=0 -> FLUSH drains the remaining words via mrd_en; no rd_valid until a new request.

Source files
------------

// File: rtl/ram_burst_controller.sv
// Burst-mode front end for one MCB user port (p0).
// Handles request/ready handshakes from the user, loads whole write bursts
// into the MCB write FIFO before issuing the command, streams read bursts
// back out, and keeps a sticky error flag.
module ram_burst_controller #(
  parameter int PORT_BITS  = 32,
  parameter int MAX_BURST  = 64,
  parameter int ADDR_WIDTH = 26
) (
  input  logic                   clk,
  input  logic                   reset,
  // user request side
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [6:0]             req_len,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [PORT_BITS-1:0]   wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [PORT_BITS-1:0]   rd_data,
  output logic                   busy,
  output logic                   error,
  // MCB p0 side
  input  logic                   calib_done,
  output logic                   cmd_en,
  output logic [2:0]             cmd_instr,
  output logic [5:0]             cmd_bl,
  output logic [29:0]            cmd_byte_addr,
  input  logic                   cmd_full,
  output logic                   mwr_en,
  output logic [PORT_BITS-1:0]   mwr_data,
  output logic [PORT_BITS/8-1:0] mwr_mask,
  input  logic                   mwr_full,
  input  logic                   mwr_underrun,
  output logic                   mrd_en,
  input  logic [PORT_BITS-1:0]   mrd_data,
  input  logic                   mrd_empty,
  input  logic                   mrd_overflow
);

  localparam int BYTE_SHIFT = $clog2(PORT_BITS / 8);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_WAIT_CAL,
    S_IDLE,
    S_WR_FILL,
    S_WR_CMD,
    S_RD_CMD,
    S_RD_DATA
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [6:0]            len_q, len_d;
  logic                  write_q, write_d;
  logic [6:0]            count_q, count_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic                  illegal_len;
  logic                  last_word;

  assign accept      = req_valid && req_ready;
  assign illegal_len = (req_len == 7'd0) || (req_len > 7'(MAX_BURST));
  assign last_word   = (7'(count_q + 7'd1) == len_q);

  // Command fields come straight from the latched request.
  assign cmd_instr     = write_q ? 3'b000 : 3'b001;
  assign cmd_bl        = 6'(len_q - 7'd1);
  assign cmd_byte_addr = 30'(addr_q) << BYTE_SHIFT;
  assign mwr_mask      = '0;
  assign mwr_data      = wr_data;
  assign rd_data       = mrd_data;
  assign error         = error_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FLUSH;
      addr_q  <= '0;
      len_q   <= '0;
      write_q <= 1'b0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      write_q <= write_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Next-state logic: transitions, request latching, word counting, sticky error.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    write_d = write_q;
    count_d = count_q;
    error_d = error_q | mwr_underrun | mrd_overflow;
    unique case (state_q)
      S_FLUSH: begin
        if (mrd_empty) state_d = S_WAIT_CAL;
      end
      S_WAIT_CAL: begin
        if (calib_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          len_d   = req_len;
          write_d = req_write;
          count_d = '0;
          if (illegal_len) begin
            error_d = 1'b1;
          end else begin
            state_d = req_write ? S_WR_FILL : S_RD_CMD;
          end
        end
      end
      S_WR_FILL: begin
        if (mwr_en) begin
          count_d = 7'(count_q + 7'd1);
          if (last_word) state_d = S_WR_CMD;
        end
      end
      S_WR_CMD: begin
        if (cmd_en) state_d = S_IDLE;
      end
      S_RD_CMD: begin
        if (cmd_en) begin
          count_d = '0;
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (mrd_en) begin
          count_d = 7'(count_q + 7'd1);
          if (last_word) state_d = S_IDLE;
        end
      end
      default: state_d = S_FLUSH;
    endcase
  end

  // Output decode: handshakes and MCB strobes for the current state.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    cmd_en    = 1'b0;
    mwr_en    = 1'b0;
    mrd_en    = 1'b0;
    unique case (state_q)
      S_FLUSH:    mrd_en = !mrd_empty;
      S_WAIT_CAL: ;
      S_IDLE:     req_ready = 1'b1;
      S_WR_FILL: begin
        busy     = 1'b1;
        wr_ready = !mwr_full;
        mwr_en   = wr_valid && !mwr_full;
      end
      S_WR_CMD, S_RD_CMD: begin
        busy   = 1'b1;
        cmd_en = !cmd_full;
      end
      S_RD_DATA: begin
        busy     = 1'b1;
        rd_valid = !mrd_empty;
        mrd_en   = !mrd_empty && rd_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_burst_controller.sv
// Directed self-checking bench for ram_burst_controller (32-bit port).
module tb_ram_burst_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic        req_ready;
  logic [25:0] req_addr;
  logic [6:0]  req_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        busy, error;
  logic        calib_done;
  logic        cmd_en, cmd_full;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        mwr_en, mwr_full, mwr_underrun;
  logic [31:0] mwr_data;
  logic [3:0]  mwr_mask;
  logic        mrd_en, mrd_empty, mrd_overflow;
  logic [31:0] mrd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_burst_controller #(.PORT_BITS(32), .MAX_BURST(64), .ADDR_WIDTH(26)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .error(error), .calib_done(calib_done),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
    .mwr_en(mwr_en), .mwr_data(mwr_data), .mwr_mask(mwr_mask),
    .mwr_full(mwr_full), .mwr_underrun(mwr_underrun),
    .mrd_en(mrd_en), .mrd_data(mrd_data), .mrd_empty(mrd_empty),
    .mrd_overflow(mrd_overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic wr, input logic [25:0] addr, input logic [6:0] len);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    step();
    req_valid = 1'b0;
  endtask

  int n;
  int got_words;

  initial begin
    reset = 1'b0; req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0; calib_done = 0; cmd_full = 0;
    mwr_full = 0; mwr_underrun = 0; mrd_data = '0; mrd_empty = 1; mrd_overflow = 0;
    repeat (3) step();
    reset = 1'b1;

    // 1: reset state, FLUSH drains three stale words, calibration -> IDLE
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      mrd_empty = 1'b0;
      #1;
      if (mrd_en) n++;
      step();
    end
    check("flush_pops", n, 3);
    mrd_empty = 1'b1;
    #1;
    check("flush_idle_mrd_en", mrd_en, 0);
    step();
    check("wait_cal_req_ready", req_ready, 0);
    calib_done = 1'b1;
    step();
    check("idle_req_ready", req_ready, 1);
    check("idle_error", error, 0);

    // 2: write burst addr 0x10 len 4, one mwr_full stall in the middle
    request(1'b1, 26'h10, 7'd4);
    check("wr_busy", busy, 1);
    check("wr_req_ready", req_ready, 0);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hCAFE_0000 + 32'(i);
      if (i == 2) begin
        mwr_full = 1'b1;
        #1;
        check("wr_full_ready", wr_ready, 0);
        check("wr_full_mwr_en", mwr_en, 0);
        step();
        mwr_full = 1'b0;
      end
      #1;
      check($sformatf("wr_mwr_en_%0d", i), mwr_en, 1);
      check($sformatf("wr_data_%0d", i), mwr_data, 32'hCAFE_0000 + 32'(i));
      check($sformatf("wr_no_cmd_%0d", i), cmd_en, 0);
      step();
    end
    wr_valid = 1'b0;
    #1;
    check("wr_cmd_en", cmd_en, 1);
    check("wr_cmd_instr", cmd_instr, 3'b000);
    check("wr_cmd_bl", cmd_bl, 6'd3);
    check("wr_cmd_addr", cmd_byte_addr, 30'h40);
    check("wr_mask", mwr_mask, 4'h0);
    step();
    check("wr_done_cmd_en", cmd_en, 0);
    check("wr_done_busy", busy, 0);
    check("wr_done_ready", req_ready, 1);

    // 3: read burst addr 0x20 len 8, mrd_empty toggling, one rd_ready=0 hold
    request(1'b0, 26'h20, 7'd8);
    #1;
    check("rd_cmd_en", cmd_en, 1);
    check("rd_cmd_instr", cmd_instr, 3'b001);
    check("rd_cmd_bl", cmd_bl, 6'd7);
    check("rd_cmd_addr", cmd_byte_addr, 30'h80);
    step();
    mrd_empty = 1'b0; rd_ready = 1'b0; mrd_data = 32'h5000_0000;
    #1;
    check("rd_hold_valid", rd_valid, 1);
    check("rd_hold_mrd_en", mrd_en, 0);
    step();
    rd_ready = 1'b1;
    got_words = 0;
    for (int c = 0; c < 40 && got_words < 8; c++) begin
      mrd_empty = (c % 2 == 1);
      mrd_data  = 32'h5000_0000 + 32'(got_words);
      #1;
      if (!mrd_empty) begin
        check($sformatf("rd_valid_%0d", got_words), rd_valid, 1);
        check($sformatf("rd_pop_%0d", got_words), mrd_en, 1);
        check($sformatf("rd_data_%0d", got_words), rd_data, 32'h5000_0000 + 32'(got_words));
        got_words++;
      end else begin
        check("rd_empty_pop", mrd_en, 0);
      end
      step();
    end
    check("rd_word_count", got_words, 8);
    mrd_empty = 1'b1;
    #1;
    check("rd_done_busy", busy, 0);
    check("rd_done_ready", req_ready, 1);
    check("rd_done_error", error, 0);

    // 4: cmd_full held 5 cycles in WR_CMD, then exactly one command
    request(1'b1, 26'h3, 7'd2);
    wr_valid = 1'b1;
    step();
    step();
    wr_valid = 1'b0;
    cmd_full = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (cmd_en) n++;
      step();
    end
    check("cmdfull_no_cmd", n, 0);
    check("cmdfull_busy", busy, 1);
    cmd_full = 1'b0;
    #1;
    check("cmdfull_release_en", cmd_en, 1);
    check("cmdfull_bl", cmd_bl, 6'd1);
    step();
    check("cmdfull_after_en", cmd_en, 0);
    check("cmdfull_idle", req_ready, 1);

    // 5: illegal lengths set sticky error; a legal read still completes
    request(1'b1, 26'h0, 7'd0);
    #1;
    check("len0_error", error, 1);
    check("len0_busy", busy, 0);
    check("len0_cmd_en", cmd_en, 0);
    request(1'b0, 26'h0, 7'd65);
    #1;
    check("len65_busy", busy, 0);
    check("len65_cmd_en", cmd_en, 0);
    request(1'b0, 26'h5, 7'd1);
    #1;
    check("legal_cmd_en", cmd_en, 1);
    check("legal_cmd_addr", cmd_byte_addr, 30'h14);
    step();
    mrd_empty = 1'b0; mrd_data = 32'h0000_BEEF;
    #1;
    check("legal_rd_data", rd_data, 32'h0000_BEEF);
    check("legal_pop", mrd_en, 1);
    step();
    mrd_empty = 1'b1;
    #1;
    check("legal_idle", req_ready, 1);
    check("legal_error_sticky", error, 1);

    // 6: reset after 2 of 8 read words; FLUSH drains the rest
    request(1'b0, 26'h40, 7'd8);
    step();
    mrd_empty = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("abort_pop_%0d", i), mrd_en, 1);
      step();
    end
    rd_ready = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    rd_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (mrd_en) n++;
      if (rd_valid) n += 100;
      step();
    end
    check("abort_flush_pops", n, 6);
    mrd_empty = 1'b1;
    #1;
    check("abort_error_cleared", error, 0);
    step();
    step();
    check("abort_idle", req_ready, 1);
    check("abort_rd_valid", rd_valid, 0);

    // Underrun flag sets the sticky error from IDLE.
    mwr_underrun = 1'b1;
    step();
    mwr_underrun = 1'b0;
    step();
    check("underrun_error", error, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
